// File: rtl/fft_frame_gen.sv
// fft_frame_gen: framed FFT sample source with mirrored audio stream, pattern select and backpressure.
// Optional macro FFT_GEN_LFSR_EN enables the 32-bit LFSR pattern on mode 3 (otherwise mode 3 = index).

module fft_frame_gen #(
  parameter int DATA_W        = 32,
  parameter int FRAME_LEN_MAX = 1024,
  parameter int LEN_W         = 11,
  parameter int GAP_CYCLES    = 4,
  parameter int CNT_W         = 16
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] const_val,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic              fft_ready,
  output logic [DATA_W-1:0] fft_data,
  output logic              fft_sop,
  output logic              fft_eop,
  output logic              fft_valid,
  output logic [15:0]       audio_data,
  output logic              audio_en,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic              busy
);

  // state | meaning
  // IDLE  | waiting for enable with a non-zero frame_len
  // RUN   | presenting the beats of the current frame
  // GAP   | idle spacing between frames, GAP_CYCLES long
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(FRAME_LEN_MAX);

  logic [1:0]        state, state_n;
  logic [LEN_W-1:0]  len, len_n, idx, idx_n, flen;
  logic [1:0]        mode_q, mode_n;
  logic [DATA_W-1:0] ramp, ramp_n, data_n, alt;
  logic [GAP_W-1:0]  gap_cnt, gap_n;
  logic [CNT_W-1:0]  cnt_n;
  logic              valid_n, sop_n, eop_n, start, load;

`ifdef FFT_GEN_LFSR_EN
  logic [31:0] lfsr, lfsr_n;
`endif

  function automatic logic [DATA_W-1:0] pattern(
    input logic [1:0]        m,
    input logic [LEN_W-1:0]  i,
    input logic [DATA_W-1:0] r,
    input logic [DATA_W-1:0] c,
    input logic [DATA_W-1:0] l
  );
    case (m)
      2'd1:    return r;
      2'd2:    return c;
      2'd3:    return l;
      default: return DATA_W'(i);
    endcase
  endfunction

  always_comb begin
    state_n = state;
    len_n   = len;
    mode_n  = mode_q;
    idx_n   = idx;
    ramp_n  = ramp;
    gap_n   = gap_cnt;
    cnt_n   = frame_cnt;
    valid_n = fft_valid;
    sop_n   = fft_sop;
    eop_n   = fft_eop;
    data_n  = fft_data;
    start   = 1'b0;
    load    = 1'b0;
    alt     = '0;
    flen    = (frame_len > LEN_MAX) ? LEN_MAX : frame_len;
`ifdef FFT_GEN_LFSR_EN
    lfsr_n  = lfsr;
`endif

    case (state)
      S_RUN: begin
        if (fft_valid && fft_ready) begin
          ramp_n = ramp + 1'b1;
`ifdef FFT_GEN_LFSR_EN
          lfsr_n = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
`endif
          idx_n = idx + 1'b1;
          if (fft_eop) begin
            cnt_n   = frame_cnt + 1'b1;
            valid_n = 1'b0;
            sop_n   = 1'b0;
            eop_n   = 1'b0;
            if (GAP_CYCLES == 0) begin
              state_n = S_IDLE;
              start   = 1'b1;
            end else begin
              state_n = S_GAP;
              gap_n   = GAP_W'(GAP_CYCLES - 1);
            end
          end else begin
            sop_n = 1'b0;
            eop_n = (idx_n == len - 1'b1);
            load  = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt == '0) begin
          state_n = S_IDLE;
          start   = 1'b1;
        end else begin
          gap_n = gap_cnt - 1'b1;
        end
      end
      default: start = 1'b1;
    endcase

    // the start decision can fire from IDLE, from the last gap cycle or straight off an eop
    if (start && enable && (frame_len != '0)) begin
      state_n = S_RUN;
      len_n   = flen;
      mode_n  = mode;
      idx_n   = '0;
      valid_n = 1'b1;
      sop_n   = 1'b1;
      eop_n   = (flen == LEN_W'(1));
      load    = 1'b1;
    end

`ifdef FFT_GEN_LFSR_EN
    alt = lfsr_n[DATA_W-1:0];
`else
    alt = DATA_W'(idx_n);
`endif
    if (load) data_n = pattern(mode_n, idx_n, ramp_n, const_val, alt);
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      len       <= '0;
      mode_q    <= '0;
      idx       <= '0;
      ramp      <= '0;
      gap_cnt   <= '0;
      frame_cnt <= '0;
      fft_valid <= 1'b0;
      fft_sop   <= 1'b0;
      fft_eop   <= 1'b0;
      fft_data  <= '0;
      busy      <= 1'b0;
`ifdef FFT_GEN_LFSR_EN
      lfsr      <= 32'h1;
`endif
    end else begin
      state     <= state_n;
      len       <= len_n;
      mode_q    <= mode_n;
      idx       <= idx_n;
      ramp      <= ramp_n;
      gap_cnt   <= gap_n;
      frame_cnt <= cnt_n;
      fft_valid <= valid_n;
      fft_sop   <= sop_n;
      fft_eop   <= eop_n;
      fft_data  <= data_n;
      busy      <= (state_n != S_IDLE);
`ifdef FFT_GEN_LFSR_EN
      lfsr      <= lfsr_n;
`endif
    end
  end

  assign audio_data = fft_data[15:0];
  assign audio_en   = fft_valid;

endmodule

// File: tb/tb_fft_frame_gen.sv
// tb_fft_frame_gen: directed stimulus on two generators (gap 4 and gap 0) with a beat-level scoreboard.

module tb_fft_frame_gen;

  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [31:0] const_val = 32'hCAFE_1234;
  logic [10:0] frame_len = 11'd0;
  logic        fft_ready = 1'b1;

  logic [1:0][31:0] data_o;
  logic [1:0][15:0] audio_o, cnt_o;
  logic [1:0]       sop_o, eop_o, valid_o, aen_o, busy_o;

  int checks = 0;
  int errors = 0;

  always #10 sys_clk = ~sys_clk;

  fft_frame_gen #(.GAP_CYCLES(4)) u_g4 (
    .sys_clk(sys_clk), .rst_n(rst_n), .enable(enable), .mode(mode),
    .const_val(const_val), .frame_len(frame_len), .fft_ready(fft_ready),
    .fft_data(data_o[0]), .fft_sop(sop_o[0]), .fft_eop(eop_o[0]), .fft_valid(valid_o[0]),
    .audio_data(audio_o[0]), .audio_en(aen_o[0]), .frame_cnt(cnt_o[0]), .busy(busy_o[0])
  );

  fft_frame_gen #(.GAP_CYCLES(0)) u_g0 (
    .sys_clk(sys_clk), .rst_n(rst_n), .enable(enable), .mode(mode),
    .const_val(const_val), .frame_len(frame_len), .fft_ready(fft_ready),
    .fft_data(data_o[1]), .fft_sop(sop_o[1]), .fft_eop(eop_o[1]), .fft_valid(valid_o[1]),
    .audio_data(audio_o[1]), .audio_en(aen_o[1]), .frame_cnt(cnt_o[1]), .busy(busy_o[1])
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // x^32 + x^22 + x^2 + x + 1, shifting towards the MSB
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], ^(s & 32'h8020_0003)};
  endfunction

  // scoreboard state, one slot per generator
  int          exp_len = 0;
  logic [1:0]  exp_mode = 2'd0;
  bit          chk_gap = 1'b0;
  int          gap_of [2] = '{4, 0};
  int          pos [2];
  int          cur_len [2];
  logic [1:0]  cur_mode [2];
  logic [31:0] ramp_m [2];
  logic [31:0] lfsr_m [2];
  logic [15:0] cnt_m [2];
  bit          gap_run [2];
  int          gap_len [2];
  int          beats [2];
  logic [31:0] sb_exp;

  initial forever begin
    @(negedge sys_clk);
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        pos[i] = 0; cur_len[i] = 0; cur_mode[i] = 2'd0; ramp_m[i] = 0; lfsr_m[i] = 32'h1;
        cnt_m[i] = 0; gap_run[i] = 1'b0; gap_len[i] = 0; beats[i] = 0;
      end else begin
        chk($sformatf("g%0d frame_cnt", i), cnt_o[i], cnt_m[i]);
        if (valid_o[i]) begin
          if (pos[i] == 0) begin
            cur_len[i]  = (exp_len > 1024) ? 1024 : exp_len;
            cur_mode[i] = exp_mode;
          end
          case (cur_mode[i])
            2'd1: sb_exp = ramp_m[i];
            2'd2: sb_exp = const_val;
`ifdef FFT_GEN_LFSR_EN
            2'd3: sb_exp = lfsr_m[i];
`else
            2'd3: sb_exp = 32'(pos[i]);
`endif
            default: sb_exp = 32'(pos[i]);
          endcase
          chk($sformatf("g%0d data beat %0d", i, pos[i]), data_o[i], sb_exp);
          chk($sformatf("g%0d audio", i), audio_o[i], sb_exp[15:0]);
          chk($sformatf("g%0d sop", i), sop_o[i], pos[i] == 0);
          chk($sformatf("g%0d eop", i), eop_o[i], pos[i] == cur_len[i] - 1);
          if (gap_run[i]) begin
            if (chk_gap) chk($sformatf("g%0d gap cycles", i), gap_len[i], gap_of[i]);
            gap_run[i] = 1'b0;
          end
          if (fft_ready) begin
            beats[i]++;
            ramp_m[i] = ramp_m[i] + 1;
            lfsr_m[i] = lfsr_step(lfsr_m[i]);
            if (pos[i] == cur_len[i] - 1) begin
              pos[i] = 0;
              cnt_m[i]++;
              gap_run[i] = 1'b1;
              gap_len[i] = 0;
            end else begin
              pos[i]++;
            end
          end
        end else if (gap_run[i]) begin
          gap_len[i]++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while ((busy_o != 2'b00) && (n < bound)) begin
      tick();
      n++;
    end
    chk("idle within bound", busy_o, 2'b00);
  endtask

  task automatic arm(input int len, input logic [1:0] m);
    frame_len = 11'(len);
    mode      = m;
    exp_len   = len;
    exp_mode  = m;
  endtask

  task automatic chk_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s g%0d data", tag, i), data_o[i], 0);
      chk($sformatf("%s g%0d sop/eop/valid", tag, i), {sop_o[i], eop_o[i], valid_o[i]}, 0);
      chk($sformatf("%s g%0d audio", tag, i), {audio_o[i], aen_o[i]}, 0);
      chk($sformatf("%s g%0d frame_cnt", tag, i), cnt_o[i], 0);
      chk($sformatf("%s g%0d busy", tag, i), busy_o[i], 0);
    end
  endtask

  logic [31:0] lit [4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
`ifdef FFT_GEN_LFSR_EN
    lit = '{32'h1, 32'h3, 32'h6, 32'hD};
`else
    lit = '{32'h0, 32'h1, 32'h2, 32'h3};
`endif
    tick();
    tick();
    chk_zero("reset");
    rst_n = 1'b1;
    tick();

    // 1: eight-beat index frame, enable pulsed
    arm(8, 2'd0);
    enable = 1'b1;
    tick();
    enable = 1'b0;
    chk("t1 valid/sop/busy", {valid_o[0], sop_o[0], busy_o[0], aen_o[0]}, 4'b1111);
    for (int k = 0; k < 8; k++) begin
      chk("t1 data g4", data_o[0], k);
      chk("t1 data g0", data_o[1], k);
      tick();
    end
    chk("t1 after eop valid", valid_o, 2'b00);
    chk("t1 frame_cnt", cnt_o[0], 1);
    chk("t1 g4 busy in gap", busy_o[0], 1);
    chk("t1 g0 busy no gap", busy_o[1], 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t1 gap valid", valid_o[0], 0);
      chk("t1 gap busy", busy_o[0], 1);
    end
    tick();
    chk("t1 busy after gap", busy_o[0], 0);

    // 2: four beats with stalls on beats 1 and 2, mode changed mid-frame
    arm(4, 2'd0);
    enable = 1'b1;
    tick();
    enable = 1'b0;
    chk("t2 beat0", {sop_o[0], data_o[0]}, {1'b1, 32'd0});
    tick();
    fft_ready = 1'b0;
    mode = 2'd2;
    for (int k = 0; k < 3; k++) begin
      chk("t2 hold1", {valid_o[0], eop_o[0], data_o[0]}, {2'b10, 32'd1});
      tick();
    end
    fft_ready = 1'b1;
    tick();
    fft_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("t2 hold2", {valid_o[0], eop_o[0], data_o[0]}, {2'b10, 32'd2});
      tick();
    end
    fft_ready = 1'b1;
    tick();
    chk("t2 beat3 eop", {valid_o[0], eop_o[0], data_o[0]}, {2'b11, 32'd3});
    tick();
    chk("t2 done valid", valid_o[0], 0);
    mode = 2'd0;
    wait_idle(20);

    // 3a: single-beat constant frame
    arm(1, 2'd2);
    enable = 1'b1;
    tick();
    enable = 1'b0;
    chk("t3 len1 flags", {valid_o[0], sop_o[0], eop_o[0]}, 3'b111);
    chk("t3 len1 data", data_o[0], 32'hCAFE_1234);
    tick();
    chk("t3 len1 valid", valid_o, 2'b00);
    chk("t3 frame_cnt g4", cnt_o[0], 3);
    chk("t3 frame_cnt g0", cnt_o[1], 3);
    wait_idle(20);

    // 3b: zero length never starts
    arm(0, 2'd0);
    enable = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t3 len0 valid", valid_o, 2'b00);
      chk("t3 len0 busy", busy_o, 2'b00);
    end
    enable = 1'b0;

    // 3c: oversize length clamps to FRAME_LEN_MAX
    arm(2000, 2'd0);
    enable = 1'b1;
    tick();
    enable = 1'b0;
    n = 0;
    for (int k = 0; k < 3000 && busy_o != 2'b00; k++) begin
      if (valid_o[0]) n++;
      tick();
    end
    chk("t3 clamp beats", n, 1024);
    wait_idle(20);

    // 4: continuous ramp frames, enable held
    do_reset();
    arm(256, 2'd1);
    chk_gap = 1'b1;
    enable = 1'b1;
    repeat (530) tick();
    enable = 1'b0;
    wait_idle(400);
    chk_gap = 1'b0;
    chk("t4 frame_cnt g0", cnt_o[1], 3);
    chk("t4 frame_cnt g4", cnt_o[0], 3);
    chk("t4 beats g0", beats[1], 768);
    chk("t4 beats g4", beats[0], 768);

    // 5: reset in the middle of a 16-beat frame
    arm(16, 2'd0);
    enable = 1'b1;
    tick();
    repeat (5) tick();
    chk("t5 beat5", data_o[0], 5);
    rst_n = 1'b0;
    tick();
    chk_zero("t5 reset");
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("t5 restart flags", {valid_o[i], sop_o[i]}, 2'b11);
      chk("t5 restart data", data_o[i], 0);
      chk("t5 restart frame_cnt", cnt_o[i], 0);
    end
    enable = 1'b0;
    wait_idle(100);

    // 6: mode 3 from a fresh seed
    do_reset();
    arm(4, 2'd3);
    enable = 1'b1;
    tick();
    enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("t6 data g4", data_o[0], lit[k]);
      chk("t6 data g0", data_o[1], lit[k]);
      tick();
    end
    wait_idle(20);
    chk("t6 model lfsr after 4", lfsr_m[0], 32'h1B);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
